// File: rtl/pattern_recorder.sv
// Serial level recorder: run lengths of a synchronised input are pushed as {level, length}
// entries into a first-word fall-through FIFO while armed.
module pattern_recorder #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 15
) (
  input  logic                     clkin,
  input  logic                     rst_n,
  input  logic                     din,
  input  logic                     arm,
  input  logic                     rd_en,
  output logic [CNT_W:0]           rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StArmed, StRecord} state_e;

  state_e           state_q;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] run_cnt_q;
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic [CNT_W:0]   mem [DEPTH];

  logic trans, clr, push, pop, full, wr_ok;

  always_comb begin
    trans = s2_q ^ s3_q;
    clr   = (state_q == StIdle) && arm;
    // Disarm wins over a coincident transition, so the unfinished run is never pushed.
    push  = (state_q == StRecord) && arm && trans;
    pop   = rd_en && (count_q != '0) && !clr;
    full  = (count_q == CW'(DEPTH));
    wr_ok = push && (!full || pop);
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      run_cnt_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      s1_q <= din;
      s2_q <= s1_q;
      s3_q <= s2_q;

      unique case (state_q)
        StIdle: begin
          if (arm) state_q <= StArmed;
        end
        StArmed: begin
          if (!arm) begin
            state_q   <= StIdle;
            run_cnt_q <= '0;
          end else if (trans) begin
            state_q   <= StRecord;
            run_cnt_q <= CNT_W'(1);
          end
        end
        StRecord: begin
          if (!arm) begin
            state_q   <= StIdle;
            run_cnt_q <= '0;
          end else if (trans) begin
            run_cnt_q <= CNT_W'(1);
          end else if (run_cnt_q != {CNT_W{1'b1}}) begin
            run_cnt_q <= run_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase

      if (clr) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
        if (push && !wr_ok) overflow_q <= 1'b1;
        if (wr_ok && !pop)      count_q <= count_q + CW'(1);
        else if (!wr_ok && pop) count_q <= count_q - CW'(1);
      end
    end
  end

  // When full with a coincident pop, wr_ptr equals rd_ptr: the slot being vacated is reused.
  always_ff @(posedge clkin) begin
    if (wr_ok) mem[wr_ptr_q] <= {s3_q, run_cnt_q};
  end

  assign rd_valid = (count_q != '0);
  assign rd_data  = rd_valid ? mem[rd_ptr_q] : '0;
  assign count    = count_q;
  assign overflow = overflow_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_pattern_recorder.sv
// Self-checking bench for pattern_recorder: directed scenarios plus randomized traffic
// compared against a run-length reference model built from edge-sampled input history.
module tb_pattern_recorder;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 15;
  localparam int MAXLEN = 32767;

  logic        clkin = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        arm = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] rd_data;
  logic        rd_valid;
  logic [3:0]  count;
  logic        overflow;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  pattern_recorder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clkin(clkin), .rst_n(rst_n), .din(din), .arm(arm), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .overflow(overflow), .busy(busy)
  );

  always #5 clkin = ~clkin;

  // Reference model: din history as sampled at each edge, mode, and edge index of last change.
  logic        hist[$];
  logic [15:0] mq[$];
  logic        movf;
  int          mode;
  int          k;
  int          last;

  function automatic void model_reset();
    hist.delete();
    repeat (3) hist.push_back(1'b0);
    mq.delete();
    movf = 1'b0;
    mode = 0;
    k    = 0;
    last = 0;
  endfunction

  function automatic void model_edge(input logic a, input logic d, input logic r);
    logic        tr, lvl, do_push, do_pop, clr;
    logic [15:0] ent;
    int          len, pre;
    // A level change takes two edges to reach the comparison point.
    tr  = hist[hist.size()-2] != hist[hist.size()-3];
    lvl = hist[hist.size()-3];
    hist.push_back(d);
    if (hist.size() > 4) void'(hist.pop_front());
    k++;
    do_push = 1'b0;
    clr = 1'b0;
    ent = '0;
    if (mode == 0) begin
      if (a) begin mode = 1; clr = 1'b1; end
    end else if (!a) begin
      mode = 0;
    end else if (tr) begin
      len = k - last;
      if (len > MAXLEN) len = MAXLEN;
      ent = {lvl, 15'(len)};
      if (mode == 2) do_push = 1'b1;
      mode = 2;
      last = k;
    end
    if (clr) begin
      mq.delete();
      movf = 1'b0;
    end else begin
      pre = mq.size();
      do_pop = r && (pre > 0);
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        if (pre < DEPTH || do_pop) mq.push_back(ent);
        else movf = 1'b1;
      end
    end
  endfunction

  function automatic logic [15:0] exp_data();
    if (mq.size() > 0) return mq[0];
    return 16'd0;
  endfunction

  function automatic logic [3:0] exp_count();
    return 4'(mq.size());
  endfunction

  task automatic step(input logic a, input logic d, input logic r);
    arm = a; din = d; rd_en = r;
    @(posedge clkin);
    model_edge(a, d, r);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; arm = 1'b0; din = 1'b0; rd_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clkin);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", count); end
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", rd_valid); end
    n_vec++; if (rd_data !== 16'd0) begin n_err++; $display("FAIL reset_data got %h exp 0", rd_data); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
    do_reset();
    repeat (5) step(1'b0, 1'b1, 1'b0);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_hold busy got %b exp 0", busy); end
    step(1'b1, 1'b1, 1'b0);
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL arm_busy got %b exp 1", busy); end
  endtask

  task automatic test_runs();
    do_reset();
    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (50) step(1'b1, 1'b1, 1'b0);
    repeat (75) step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b1, 1'b0);
    n_vec++; if (count !== 4'd2) begin n_err++; $display("FAIL runs_count got %0d exp 2", count); end
    n_vec++; if (rd_data !== {1'b1, 15'd50}) begin n_err++; $display("FAIL runs_head got %h exp %h", rd_data, {1'b1, 15'd50}); end
    step(1'b1, 1'b1, 1'b1);
    n_vec++; if (rd_data !== {1'b0, 15'd75}) begin n_err++; $display("FAIL runs_second got %h exp %h", rd_data, {1'b0, 15'd75}); end
    step(1'b1, 1'b1, 1'b1);
    n_vec++; if (rd_valid !== 1'b0 || rd_data !== 16'd0) begin n_err++; $display("FAIL runs_empty got valid=%b data=%h exp 0/0", rd_valid, rd_data); end
    step(1'b1, 1'b1, 1'b1);
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL runs_empty_pop count got %0d exp 0", count); end
  endtask

  task automatic test_overflow();
    int h[10];
    logic d;
    do_reset();
    d = 1'b0;
    repeat (3) step(1'b1, d, 1'b0);
    for (int i = 0; i < 10; i++) begin
      h[i] = $urandom_range(6, 3);
      d = ~d;
      repeat (h[i]) step(1'b1, d, 1'b0);
    end
    n_vec++; if (count !== 4'd8) begin n_err++; $display("FAIL ovf_count got %0d exp 8", count); end
    n_vec++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    n_vec++; if (rd_data !== {1'b1, 15'(h[0])}) begin n_err++; $display("FAIL ovf_head got %h exp %h", rd_data, {1'b1, 15'(h[0])}); end
    n_vec++; if (rd_data !== exp_data()) begin n_err++; $display("FAIL ovf_head_model got %h exp %h", rd_data, exp_data()); end
  endtask

  task automatic test_full_pop();
    int h[9];
    logic d;
    do_reset();
    d = 1'b0;
    repeat (3) step(1'b1, d, 1'b0);
    for (int i = 0; i < 9; i++) begin
      h[i] = $urandom_range(6, 3);
      d = ~d;
      repeat (h[i]) step(1'b1, d, 1'b0);
    end
    n_vec++; if (count !== 4'd8 || overflow !== 1'b0) begin n_err++; $display("FAIL full_pre got count=%0d ovf=%b exp 8/0", count, overflow); end
    d = ~d;
    step(1'b1, d, 1'b0);
    step(1'b1, d, 1'b0);
    step(1'b1, d, 1'b1);
    n_vec++; if (count !== 4'd8) begin n_err++; $display("FAIL full_pop_count got %0d exp 8", count); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_pop_ovf got %b exp 0", overflow); end
    n_vec++; if (rd_data !== {1'b0, 15'(h[1])}) begin n_err++; $display("FAIL full_pop_head got %h exp %h", rd_data, {1'b0, 15'(h[1])}); end
    for (int i = 0; i < 8; i++) begin
      n_vec++; if (rd_data !== exp_data()) begin n_err++; $display("FAIL full_drain[%0d] got %h exp %h", i, rd_data, exp_data()); end
      step(1'b1, d, 1'b1);
    end
    n_vec++; if (count !== 4'd0) begin n_err++; $display("FAIL full_drain_count got %0d exp 0", count); end
  endtask

  task automatic test_saturate();
    do_reset();
    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (40000) step(1'b1, 1'b1, 1'b0);
    repeat (4) step(1'b1, 1'b0, 1'b0);
    n_vec++; if (rd_data !== {1'b1, 15'd32767}) begin n_err++; $display("FAIL sat_len got %h exp %h", rd_data, {1'b1, 15'd32767}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b1, 1'b0);
    repeat (4) step(1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b1, 1'b0);
    n_vec++; if (count !== 4'd2 || busy !== 1'b1) begin n_err++; $display("FAIL mid_pre got count=%0d busy=%b exp 2/1", count, busy); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if ({count, rd_valid, rd_data, overflow, busy} !== 23'd0) begin
      n_err++; $display("FAIL mid_reset got count=%0d valid=%b data=%h ovf=%b busy=%b exp all 0", count, rd_valid, rd_data, overflow, busy);
    end
    #1 rst_n = 1'b1;
    model_reset();
    step(1'b0, 1'b1, 1'b0);
    n_vec++; if (busy !== 1'b0 || count !== 4'd0) begin n_err++; $display("FAIL mid_release got busy=%b count=%0d exp 0/0", busy, count); end
  endtask

  task automatic test_disarm();
    do_reset();
    repeat (3) step(1'b1, 1'b0, 1'b0);
    repeat (5) step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    n_vec++; if (busy !== 1'b0 || count !== 4'd0) begin n_err++; $display("FAIL disarm got busy=%b count=%0d exp 0/0", busy, count); end
    // Second transition detected on the very edge where arm is sampled low.
    repeat (3) step(1'b1, 1'b1, 1'b0);
    repeat (5) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b1, 1'b0);
    n_vec++; if (count !== 4'd0 || busy !== 1'b0) begin n_err++; $display("FAIL disarm_edge got count=%0d busy=%b exp 0/0", count, busy); end
  endtask

  task automatic test_random();
    logic a, d, r;
    do_reset();
    a = 1'b1; d = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      if (a) a = ($urandom_range(99) >= 2);
      else   a = ($urandom_range(9) == 0);
      if ($urandom_range(3) == 0) d = ~d;
      r = ($urandom_range(2) == 0);
      step(a, d, r);
      n_vec++; if (count !== exp_count()) begin n_err++; $display("FAIL rand_count cyc %0d got %0d exp %0d", c, count, exp_count()); end
      n_vec++; if (rd_valid !== (mq.size() > 0)) begin n_err++; $display("FAIL rand_valid cyc %0d got %b exp %b", c, rd_valid, mq.size() > 0); end
      n_vec++; if (rd_data !== exp_data()) begin n_err++; $display("FAIL rand_data cyc %0d got %h exp %h", c, rd_data, exp_data()); end
      n_vec++; if (overflow !== movf) begin n_err++; $display("FAIL rand_ovf cyc %0d got %b exp %b", c, overflow, movf); end
      n_vec++; if (busy !== (mode != 0)) begin n_err++; $display("FAIL rand_busy cyc %0d got %b exp %b", c, busy, mode != 0); end
    end
  endtask

  initial begin
    test_reset();
    test_runs();
    test_overflow();
    test_full_pop();
    test_saturate();
    test_reset_mid();
    test_disarm();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
